// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access engine: widths, AluOp codes,
// FSM states and a decoder turning an AluOp into load/store attributes.
package mem_access_ctrl_pkg;

    localparam int REG_ADDR_W = 5;   // RegAddrBus
    localparam int REG_W      = 32;  // RegBus
    localparam int MEM_ADDR_W = 32;  // MemAddrBus
    localparam int ALUOP_W    = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [ALUOP_W-1:0]    aluop_t;

    localparam aluop_t ALU_LB  = 8'hE0;
    localparam aluop_t ALU_LH  = 8'hE1;
    localparam aluop_t ALU_LW  = 8'hE3;
    localparam aluop_t ALU_LBU = 8'hE4;
    localparam aluop_t ALU_LHU = 8'hE5;
    localparam aluop_t ALU_SB  = 8'hE8;
    localparam aluop_t ALU_SH  = 8'hE9;
    localparam aluop_t ALU_SW  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // last_idx is the byte count minus one, i.e. the cnt value of the final byte.
    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [1:0] last_idx;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input aluop_t op);
        mem_op_t d;
        d = '0;
        case (op)
            ALU_LB, ALU_LBU: begin d.is_load  = 1'b1; d.last_idx = 2'd0; end
            ALU_LH, ALU_LHU: begin d.is_load  = 1'b1; d.last_idx = 2'd1; end
            ALU_LW:          begin d.is_load  = 1'b1; d.last_idx = 2'd3; end
            ALU_SB:          begin d.is_store = 1'b1; d.last_idx = 2'd0; end
            ALU_SH:          begin d.is_store = 1'b1; d.last_idx = 2'd1; end
            ALU_SW:          begin d.is_store = 1'b1; d.last_idx = 2'd3; end
            default:         d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational load formatter: widens the assembled load buffer to register
// width with sign or zero extension according to the load opcode.
module mem_access_ctrl_load_extend
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = REG_W
) (
    input  logic [DATA_W-1:0]  load_buf_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    output logic [DATA_W-1:0]  data_o
);

    always_comb begin
        data_o = load_buf_i;
        case (aluop_i)
            ALU_LB:  data_o = {{(DATA_W-8){load_buf_i[7]}},   load_buf_i[7:0]};
            ALU_LBU: data_o = {{(DATA_W-8){1'b0}},            load_buf_i[7:0]};
            ALU_LH:  data_o = {{(DATA_W-16){load_buf_i[15]}}, load_buf_i[15:0]};
            ALU_LHU: data_o = {{(DATA_W-16){1'b0}},           load_buf_i[15:0]};
            default: data_o = load_buf_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage engine: executes loads/stores as byte-serial request/ack transfers,
// stalls the pipeline while a transfer is in flight and drives the MEM/WB fields.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = REG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] mem_reg_waddr,
    input  logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_reg_wdata,
    input  logic [ADDR_W-1:0]     mem_mem_addr,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [DATA_W-1:0]     mem_rt_data,
    input  logic [5:0]            stall,
    output logic [REG_ADDR_W-1:0] wb_reg_waddr,
    output logic                  wb_we,
    output logic [DATA_W-1:0]     wb_reg_wdata,
    output logic                  stallreq_mem,
    output logic                  bus_req,
    output logic                  bus_rw,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [7:0]            bus_wdata,
    input  logic [7:0]            bus_rdata,
    input  logic                  bus_ack
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] load_buf_q, load_buf_d;

    mem_op_t           op_dec;
    logic              is_mem_op;
    logic [4:0]        byte_lsb;
    logic [DATA_W-1:0] load_data;

    // Only the MEM/WB hold bit matters here; the rest of the vector is ignored.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    assign op_dec    = decode_mem_op(mem_aluop);
    assign is_mem_op = op_dec.is_load | op_dec.is_store;
    assign byte_lsb  = {cnt_q, 3'b000};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_buf_d   = load_buf_q;
        stallreq_mem = 1'b0;
        bus_req      = 1'b0;
        bus_rw       = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (is_mem_op) begin
                    stallreq_mem = 1'b1;
                    cnt_d        = 2'd0;
                    load_buf_d   = '0;
                    state_d      = ST_XFER;
                end
            end
            ST_XFER: begin
                // Address and data depend only on cnt and held EX/MEM inputs,
                // so they stay stable while waiting for ack.
                stallreq_mem = 1'b1;
                bus_req      = 1'b1;
                bus_rw       = op_dec.is_store;
                bus_addr     = mem_mem_addr + ADDR_W'(cnt_q);
                bus_wdata    = mem_rt_data[byte_lsb +: 8];
                if (bus_ack) begin
                    if (op_dec.is_load) begin
                        load_buf_d[byte_lsb +: 8] = bus_rdata;
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == op_dec.last_idx) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Holding here under stall[4] keeps the held instruction from
                // being seen as a new request in IDLE.
                if (!stall[4]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            stallreq_mem = 1'b0;
            bus_req      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from pre-edge values.
        if (rst) begin
            // NOTE: the load buffer is an ordinary register (one word), so it is
            // reset along with the FSM rather than left uninitialised.
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            load_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_buf_q <= load_buf_d;
        end
    end

    mem_access_ctrl_load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .load_buf_i (load_buf_q),
        .aluop_i    (mem_aluop),
        .data_o     (load_data)
    );

    assign wb_reg_waddr = rst ? '0   : mem_reg_waddr;
    assign wb_we        = rst ? 1'b0 : mem_we;
    assign wb_reg_wdata = rst ? '0   : (op_dec.is_load ? load_data : mem_reg_wdata);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues instructions and queues
// expected bus bytes and write-back results; a bus responder and a commit
// monitor pop and compare independently.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_reg_waddr;
    logic        mem_we;
    logic [31:0] mem_reg_wdata;
    logic [31:0] mem_mem_addr;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_rt_data;
    logic [5:0]  stall;
    logic [4:0]  wb_reg_waddr;
    logic        wb_we;
    logic [31:0] wb_reg_wdata;
    logic        stallreq_mem;
    logic        bus_req;
    logic        bus_rw;
    logic [31:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_reg_waddr (mem_reg_waddr),
        .mem_we        (mem_we),
        .mem_reg_wdata (mem_reg_wdata),
        .mem_mem_addr  (mem_mem_addr),
        .mem_aluop     (mem_aluop),
        .mem_rt_data   (mem_rt_data),
        .stall         (stall),
        .wb_reg_waddr  (wb_reg_waddr),
        .wb_we         (wb_we),
        .wb_reg_wdata  (wb_reg_wdata),
        .stallreq_mem  (stallreq_mem),
        .bus_req       (bus_req),
        .bus_rw        (bus_rw),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [4:0] waddr; logic we; logic [31:0] wdata; } wb_exp_t;
    typedef struct { logic [31:0] addr; logic rw; logic [7:0] wdata; } bus_exp_t;

    wb_exp_t    wb_q[$];
    bus_exp_t   bus_q[$];
    logic [7:0] ref_mem [logic [31:0]];  // model's view of memory
    logic [7:0] bus_mem [logic [31:0]];  // contents actually written over the bus

    int   n_checks = 0;
    int   n_errors = 0;
    logic tb_valid = 1'b0;
    int   ack_delay = 0;                  // <0: random 0..2 wait cycles per byte

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction

    function automatic int next_delay();
        return (ack_delay < 0) ? int'($urandom_range(0, 2)) : ack_delay;
    endfunction

    function automatic int model_nbytes(input logic [7:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            ALU_LW, ALU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit model_is_store(input logic [7:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        bus_mem[a] = d;
    endtask

    // Bus responder: decides ack at the falling edge; a byte completes at the next rising edge.
    initial begin : responder
        int         wait_left;
        logic       hold_valid;
        logic [31:0] hold_addr;
        logic       hold_rw;
        logic [7:0] hold_wdata;
        bus_exp_t   e;
        bus_ack    = 1'b0;
        bus_rdata  = 8'h00;
        wait_left  = 0;
        hold_valid = 1'b0;
        hold_addr  = '0;
        hold_rw    = 1'b0;
        hold_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (hold_valid) begin
                    check("bus_addr held", bus_addr, hold_addr);
                    check("bus_rw held", 32'(bus_rw), 32'(hold_rw));
                    check("bus_wdata held", 32'(bus_wdata), 32'(hold_wdata));
                end
                if (wait_left > 0) begin
                    wait_left--;
                    bus_ack    = 1'b0;
                    bus_rdata  = 8'($urandom);
                    hold_valid = 1'b1;
                    hold_addr  = bus_addr;
                    hold_rw    = bus_rw;
                    hold_wdata = bus_wdata;
                end else begin
                    bus_ack    = 1'b1;
                    hold_valid = 1'b0;
                    if (bus_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected bus byte: actual addr=0x%08h rw=%0d required no transfer",
                                 bus_addr, bus_rw);
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_addr", bus_addr, e.addr);
                        check("bus_rw", 32'(bus_rw), 32'(e.rw));
                        if (e.rw) check("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
                    end
                    if (bus_rw) bus_mem[bus_addr] = bus_wdata;
                    else        bus_rdata = bus_rd(bus_addr);
                    wait_left = next_delay();
                end
            end else begin
                bus_ack    = 1'b0;
                bus_rdata  = 8'($urandom);
                hold_valid = 1'b0;
                wait_left  = next_delay();
            end
        end
    end

    // Commit monitor: an instruction leaves MEM on any unstalled, unreset cycle.
    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (tb_valid && !rst && !stallreq_mem && !stall[4]) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected commit: actual waddr=%0d required none", wb_reg_waddr);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_reg_waddr", 32'(wb_reg_waddr), 32'(e.waddr));
                    check("wb_we", 32'(wb_we), 32'(e.we));
                    check("wb_reg_wdata", wb_reg_wdata, e.wdata);
                end
            end
        end
    end

    task automatic drive_bubble();
        mem_aluop     = 8'h00;
        mem_reg_waddr = '0;
        mem_we        = 1'b0;
        mem_reg_wdata = '0;
        mem_mem_addr  = '0;
        mem_rt_data   = '0;
    endtask

    // Called just after a rising edge; queues expectations and presents the instruction.
    task automatic issue_start(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                               input logic [4:0] waddr, input logic we, input logic [31:0] regw);
        int          n;
        logic [31:0] a;
        logic [31:0] val;
        wb_exp_t     w;
        bus_exp_t    b;
        n       = model_nbytes(op);
        w.waddr = waddr;
        w.we    = we;
        w.wdata = regw;
        val     = '0;
        for (int i = 0; i < n; i++) begin
            a       = addr + 32'(i);
            b.addr  = a;
            b.rw    = model_is_store(op);
            b.wdata = rt[8*i +: 8];
            bus_q.push_back(b);
            if (model_is_store(op)) ref_mem[a] = rt[8*i +: 8];
            else                    val[8*i +: 8] = ref_rd(a);
        end
        case (op)
            ALU_LB:  w.wdata = 32'($signed(val[7:0]));
            ALU_LBU: w.wdata = 32'(val[7:0]);
            ALU_LH:  w.wdata = 32'($signed(val[15:0]));
            ALU_LHU: w.wdata = 32'(val[15:0]);
            ALU_LW:  w.wdata = val;
            default: ;
        endcase
        wb_q.push_back(w);
        mem_aluop     = op;
        mem_mem_addr  = addr;
        mem_rt_data   = rt;
        mem_reg_waddr = waddr;
        mem_we        = we;
        mem_reg_wdata = regw;
        tb_valid      = 1'b1;
    endtask

    // Waits for the commit cycle (bounded) and returns stallreq_mem high cycles seen.
    task automatic wait_commit(output int stall_cycles);
        bit committed;
        committed    = 1'b0;
        stall_cycles = 0;
        for (int c = 0; c < 400 && !committed; c++) begin
            @(negedge clk);
            if (stallreq_mem) stall_cycles++;
            if (!rst && !stallreq_mem && !stall[4]) begin
                committed = 1'b1;
                check("bus_req low at commit", 32'(bus_req), 32'd0);
            end
        end
        if (!committed) begin
            n_checks++;
            n_errors++;
            $display("FAIL commit timeout: actual no commit in 400 cycles required commit");
        end
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        drive_bubble();
    endtask

    task automatic run(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [4:0] waddr, input logic we, input logic [31:0] regw,
                       output int stall_cycles);
        issue_start(op, addr, rt, waddr, we, regw);
        wait_commit(stall_cycles);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int          sc;
        bit          reached;
        logic [7:0]  ops [11];
        logic [7:0]  op;
        logic [31:0] addr;
        int          sel;

        ops = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_SB, ALU_SH, ALU_SW, 8'h00, 8'h21, 8'h25};

        // Reset with a memory op and live write-back fields on the inputs.
        rst           = 1'b1;
        stall         = 6'b0;
        mem_aluop     = ALU_LW;
        mem_reg_waddr = 5'h1F;
        mem_we        = 1'b1;
        mem_reg_wdata = 32'hFFFF_FFFF;
        mem_mem_addr  = 32'h100;
        mem_rt_data   = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset stallreq_mem", 32'(stallreq_mem), 32'd0);
        check("reset wb_reg_waddr", 32'(wb_reg_waddr), 32'd0);
        check("reset wb_we", 32'(wb_we), 32'd0);
        check("reset wb_reg_wdata", wb_reg_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bubble();

        // LW at 0x100 with ack every cycle.
        ack_delay = 0;
        preload(32'h100, 8'h78);
        preload(32'h101, 8'h56);
        preload(32'h102, 8'h34);
        preload(32'h103, 8'h12);
        run(ALU_LW, 32'h100, 32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF, sc);
        check("LW stall cycles", 32'(sc), 32'd5);

        // Byte/half loads with extension.
        preload(32'h40, 8'h80);
        preload(32'h50, 8'h01);
        preload(32'h51, 8'h80);
        run(ALU_LB,  32'h40, 32'h0, 5'd4, 1'b1, 32'h1111_1111, sc);
        check("LB stall cycles", 32'(sc), 32'd2);
        run(ALU_LBU, 32'h40, 32'h0, 5'd5, 1'b1, 32'h2222_2222, sc);
        run(ALU_LHU, 32'h50, 32'h0, 5'd6, 1'b1, 32'h3333_3333, sc);

        // Unaligned SH crossing into the next word.
        run(ALU_SH, 32'h203, 32'hABCD_1234, 5'd7, 1'b0, 32'h4444_4444, sc);
        check("SH stall cycles", 32'(sc), 32'd3);

        // LW with three wait cycles per byte.
        ack_delay = 3;
        run(ALU_LW, 32'h100, 32'h0, 5'd8, 1'b1, 32'h0, sc);
        check("LW delayed stall cycles", 32'(sc), 32'd17);
        ack_delay = 0;

        // LH across the address wrap, held in DONE by stall[4] for two edges.
        preload(32'hFFFF_FFFF, 8'h34);
        preload(32'h0000_0000, 8'h92);
        stall = 6'b010000;
        issue_start(ALU_LH, 32'hFFFF_FFFF, 32'h0, 5'd9, 1'b1, 32'h5555_5555);
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge clk);
            if (!stallreq_mem) reached = 1'b1;
        end
        check("LH reached DONE", 32'(reached), 32'd1);
        check("DONE hold wb_reg_wdata", wb_reg_wdata, 32'hFFFF_9234);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("DONE hold stallreq_mem", 32'(stallreq_mem), 32'd0);
        check("DONE hold bus_req", 32'(bus_req), 32'd0);
        check("DONE hold wb_reg_wdata 2", wb_reg_wdata, 32'hFFFF_9234);
        @(posedge clk);
        #1;
        stall = 6'b0;
        wait_commit(sc);

        // Reset during the third byte of an SW: only bytes 0 and 1 reach memory.
        begin : reset_abort
            bus_exp_t b;
            for (int i = 0; i < 2; i++) begin
                b.addr  = 32'h380 + 32'(i);
                b.rw    = 1'b1;
                b.wdata = 8'(32'hCAFE_BABE >> (8*i));
                bus_q.push_back(b);
                ref_mem[b.addr] = b.wdata;
            end
            mem_aluop     = ALU_SW;
            mem_mem_addr  = 32'h380;
            mem_rt_data   = 32'hCAFE_BABE;
            mem_reg_waddr = 5'd10;
            mem_we        = 1'b1;
            mem_reg_wdata = 32'h7777_7777;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            check("mid-XFER rst bus_req", 32'(bus_req), 32'd0);
            check("mid-XFER rst stallreq_mem", 32'(stallreq_mem), 32'd0);
            check("mid-XFER rst wb_we", 32'(wb_we), 32'd0);
            check("mid-XFER rst wb_reg_wdata", wb_reg_wdata, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            drive_bubble();
        end
        run(8'h00, 32'h0, 32'h0, 5'd11, 1'b1, 32'hCAFE_F00D, sc);
        check("bubble stall cycles", 32'(sc), 32'd0);
        run(ALU_LW, 32'h380, 32'h0, 5'd12, 1'b1, 32'h0, sc);
        run(8'h21, 32'h104, 32'h0, 5'd13, 1'b1, 32'h1357_9BDF, sc);

        // Randomized mix with random ack latency.
        ack_delay = -1;
        for (int k = 0; k < 80; k++) begin
            op  = ops[$urandom_range(0, 10)];
            sel = int'($urandom_range(0, 3));
            if (sel < 2)       addr = 32'h300 + 32'($urandom_range(0, 31));
            else if (sel == 2) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else               addr = $urandom;
            run(op, addr, $urandom, 5'($urandom),
                (model_nbytes(op) == 0) ? 1'($urandom) : !model_is_store(op), $urandom, sc);
        end

        repeat (3) @(posedge clk);
        check("wb queue drained", 32'(wb_q.size()), 32'd0);
        check("bus queue drained", 32'(bus_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
